// File: rtl/ucsbece154a_dmem_responder_pkg.sv
// ucsbece154a_dmem_responder_pkg
//   Shared types and constants for the data-memory responder.
//   - mem_size_* access-size encodings (2'b11 is reserved and reported as an error)
//   - dmem_state_t FSM state encoding
//   - dmem_load_extend(): lane selection and sign/zero extension of a load
package ucsbece154a_dmem_responder_pkg;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
    localparam logic [1:0] MEM_SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'b00,
        DMEM_WAIT = 2'b01,
        DMEM_RESP = 2'b10
    } dmem_state_t;

    // Pick the addressed byte/half out of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] dmem_load_extend(
        input logic [31:0] word,
        input logic [1:0]  lo,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lo, 3'b000});
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            MEM_SIZE_BYTE: dmem_load_extend = {{24{~uns & b[7]}}, b};
            MEM_SIZE_HALF: dmem_load_extend = {{16{~uns & h[15]}}, h};
            default:       dmem_load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/ucsbece154a_dmem_responder_if.sv
// ucsbece154a_dmem_responder_if
//   Request/response bus between the core's memory-request logic (master)
//   and the data-memory responder (slave).
//   req_*: valid/ready request with we, size, unsigned, addr, wdata
//   rsp_*: valid/ready response with rdata and err
interface ucsbece154a_dmem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i,
               req_addr_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i,
               req_addr_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/ucsbece154a_dmem_ram.sv
// ucsbece154a_dmem_ram
//   DEPTH_WORDS x 32 storage, synchronous byte-lane write, combinational read.
//   clk      in  clock, rising edge
//   i_we     in  per-byte write enable (bit i -> bits [8i+7:8i])
//   i_addr   in  word index
//   i_wdata  in  write data, already steered onto its lanes
//   o_rdata  out word at i_addr
//   Contents are not reset.
module ucsbece154a_dmem_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/ucsbece154a_dmem_responder.sv
// ucsbece154a_dmem_responder
//   Accepts one load/store request, waits WAIT_CYCLES, performs the byte-lane
//   write or extended read on a local RAM, and returns a response.
//   clk      in  clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      slave side of ucsbece154a_dmem_responder_if (request/response)
//   Request accepted at edge N -> rsp_valid_o high after edge N+WAIT_CYCLES+1.
module ucsbece154a_dmem_responder
    import ucsbece154a_dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    ucsbece154a_dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic [31:0] w_off;
    logic        w_err;
    logic        w_fire;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [3:0]  w_ram_we;
    logic [31:0] w_rdata;

    assign w_off  = r_addr - BASE_ADDR;   // wraps below BASE_ADDR, so one compare covers both ends
    assign w_fire = (r_state == DMEM_WAIT) && (r_cnt == 4'd0);

    always_comb begin
        w_err = (w_off >= 32'(4 * DEPTH_WORDS));
        case (r_size)
            MEM_SIZE_HALF: if (r_addr[0])          w_err = 1'b1;
            MEM_SIZE_WORD: if (r_addr[1:0] != 2'b0) w_err = 1'b1;
            MEM_SIZE_RSVD:                         w_err = 1'b1;
            default: ;
        endcase
    end

    // Replicate store data across lanes so the enable mask alone picks the target.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = r_wdata;
        case (r_size)
            MEM_SIZE_BYTE: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            MEM_SIZE_HALF: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            MEM_SIZE_WORD: w_be = 4'b1111;
            default: ;
        endcase
    end

    // Only on the WAIT->RESP edge, so a reset in WAIT never lets a store land.
    assign w_ram_we = (w_fire && r_we && !w_err) ? w_be : 4'b0000;

    ucsbece154a_dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_off[AW+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // WAIT always lasts WAIT_CYCLES+1 cycles (cnt loaded with WAIT_CYCLES and
    // leaves at 0); this gives the N+WAIT_CYCLES+1 response latency, including
    // the WAIT_CYCLES==0 case.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= DMEM_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_size      <= MEM_SIZE_BYTE;
            r_uns       <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                DMEM_IDLE: begin
                    if (bus.req_valid_i) begin
                        r_we        <= bus.req_we_i;
                        r_size      <= bus.req_size_i;
                        r_uns       <= bus.req_unsigned_i;
                        r_addr      <= bus.req_addr_i;
                        r_wdata     <= bus.req_wdata_i;
                        r_cnt       <= 4'(WAIT_CYCLES);
                        r_req_ready <= 1'b0;
                        r_state     <= DMEM_WAIT;
                    end
                end
                DMEM_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err || r_we) ? 32'd0
                                     : dmem_load_extend(w_rdata, r_addr[1:0], r_size, r_uns);
                        r_state     <= DMEM_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DMEM_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= DMEM_IDLE;
                    end
                end
                default: r_state <= DMEM_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = r_req_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.rsp_err_o   = r_rsp_err;
endmodule

// File: tb/tb_ucsbece154a_dmem_responder.sv
// tb_ucsbece154a_dmem_responder
//   Directed tests of the data-memory responder with WAIT_CYCLES=2,
//   BASE_ADDR=0x1000_0000, DEPTH_WORDS=64. Inputs driven and outputs sampled
//   on the falling edge.
module tb_ucsbece154a_dmem_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   passed = 0;
    int   total  = 0;

    ucsbece154a_dmem_responder_if bus();

    ucsbece154a_dmem_responder #(
        .DEPTH_WORDS (64),
        .BASE_ADDR   (32'h1000_0000),
        .WAIT_CYCLES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Starts and ends just after a falling edge with the responder idle.
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        bus.req_we_i       = we;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = a;
        bus.req_wdata_i    = wd;
        bus.req_valid_i    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        lat = 0;
        while (!bus.rsp_valid_o && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rd = bus.rsp_rdata_o;
        er = bus.rsp_err_o;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'd0;
        bus.req_wdata_i    = 32'd0;
        bus.rsp_ready_i    = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (bus.req_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.req_ready_o); else passed++;
        total++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.rsp_valid_o); else passed++;
        total++; if (bus.rsp_rdata_o !== 32'd0) $display("FAIL reset_rdata got %h want 0", bus.rsp_rdata_o); else passed++;
        total++; if (bus.rsp_err_o !== 1'b0) $display("FAIL reset_err got %b want 0", bus.rsp_err_o); else passed++;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 2'b10, 1'b0, 32'h1000_0008, 32'hDEAD_BEEF, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'd0}) $display("FAIL sw_rsp got err=%b rdata=%h want 0/0", er, rd); else passed++;
        total++; if (lat !== 3) $display("FAIL sw_latency got %0d want 3", lat); else passed++;
        xact(1'b0, 2'b10, 1'b0, 32'h1000_0008, 32'd0, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'hDEAD_BEEF}) $display("FAIL lw_rsp got err=%b rdata=%h want 0/deadbeef", er, rd); else passed++;
        total++; if (lat !== 3) $display("FAIL lw_latency got %0d want 3", lat); else passed++;
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 2'b00, 1'b0, 32'h1000_0009, 32'h0000_0080, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'd0}) $display("FAIL sb_rsp got err=%b rdata=%h want 0/0", er, rd); else passed++;
        xact(1'b0, 2'b00, 1'b0, 32'h1000_0009, 32'd0, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'hFFFF_FF80}) $display("FAIL lb got err=%b rdata=%h want 0/ffffff80", er, rd); else passed++;
        xact(1'b0, 2'b00, 1'b1, 32'h1000_0009, 32'd0, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'h0000_0080}) $display("FAIL lbu got err=%b rdata=%h want 0/00000080", er, rd); else passed++;
        xact(1'b0, 2'b10, 1'b0, 32'h1000_0008, 32'd0, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'hDEAD_80EF}) $display("FAIL lw_after_sb got err=%b rdata=%h want 0/dead80ef", er, rd); else passed++;
        xact(1'b0, 2'b01, 1'b0, 32'h1000_000A, 32'd0, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'hFFFF_DEAD}) $display("FAIL lh_hi got err=%b rdata=%h want 0/ffffdead", er, rd); else passed++;
        xact(1'b0, 2'b01, 1'b1, 32'h1000_000A, 32'd0, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'h0000_DEAD}) $display("FAIL lhu_hi got err=%b rdata=%h want 0/0000dead", er, rd); else passed++;
        xact(1'b0, 2'b00, 1'b0, 32'h1000_0008, 32'd0, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'hFFFF_FFEF}) $display("FAIL lb_lane0 got err=%b rdata=%h want 0/ffffffef", er, rd); else passed++;
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, 2'b01, 1'b0, 32'h1000_0003, 32'd0, rd, er, lat);
        total++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL lh_misaligned got err=%b rdata=%h want 1/0", er, rd); else passed++;
        total++; if (lat !== 3) $display("FAIL err_latency got %0d want 3", lat); else passed++;
        xact(1'b1, 2'b10, 1'b0, 32'h1000_000A, 32'h1234_5678, rd, er, lat);
        total++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL sw_misaligned got err=%b rdata=%h want 1/0", er, rd); else passed++;
        xact(1'b0, 2'b10, 1'b0, 32'h1000_0008, 32'd0, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'hDEAD_80EF}) $display("FAIL lw_after_bad_sw got err=%b rdata=%h want 0/dead80ef", er, rd); else passed++;
    endtask

    task automatic test_range();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 2'b10, 1'b0, 32'h1000_0000, 32'h1122_3344, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'd0}) $display("FAIL sw_word0 got err=%b rdata=%h want 0/0", er, rd); else passed++;
        xact(1'b0, 2'b10, 1'b0, 32'h1000_0100, 32'd0, rd, er, lat);
        total++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL lw_above got err=%b rdata=%h want 1/0", er, rd); else passed++;
        xact(1'b0, 2'b10, 1'b0, 32'h0FFF_FFFC, 32'd0, rd, er, lat);
        total++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL lw_below got err=%b rdata=%h want 1/0", er, rd); else passed++;
        xact(1'b1, 2'b11, 1'b0, 32'h1000_0000, 32'hFFFF_FFFF, rd, er, lat);
        total++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL size_rsvd got err=%b rdata=%h want 1/0", er, rd); else passed++;
        xact(1'b1, 2'b10, 1'b0, 32'h1000_0100, 32'hFFFF_FFFF, rd, er, lat);
        total++; if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL sw_above got err=%b rdata=%h want 1/0", er, rd); else passed++;
        xact(1'b0, 2'b10, 1'b0, 32'h1000_0000, 32'd0, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'h1122_3344}) $display("FAIL word0_intact got err=%b rdata=%h want 0/11223344", er, rd); else passed++;
        xact(1'b1, 2'b01, 1'b0, 32'h1000_0008, 32'hAAAA_7FFF, rd, er, lat);
        xact(1'b0, 2'b10, 1'b0, 32'h1000_0008, 32'd0, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'hDEAD_7FFF}) $display("FAIL sh_lo got err=%b rdata=%h want 0/dead7fff", er, rd); else passed++;
    endtask

    task automatic test_backpressure();
        int lat;
        bus.req_we_i = 1'b0; bus.req_size_i = 2'b10; bus.req_unsigned_i = 1'b0;
        bus.req_addr_i = 32'h1000_0008; bus.req_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Keep a different request pending; it must be ignored until IDLE.
        bus.req_addr_i = 32'h1000_0000;
        lat = 0;
        while (!bus.rsp_valid_o && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        total++; if (lat !== 3) $display("FAIL bp_latency got %0d want 3", lat); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            total++;
            if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o, bus.req_ready_o} !== {1'b1, 1'b0, 32'hDEAD_7FFF, 1'b0})
                $display("FAIL bp_hold%0d got v=%b e=%b d=%h rdy=%b want 1/0/dead7fff/0", i,
                         bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o, bus.req_ready_o);
            else passed++;
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        total++;
        if ({bus.rsp_valid_o, bus.req_ready_o} !== 2'b01)
            $display("FAIL bp_release got v=%b rdy=%b want 0/1", bus.rsp_valid_o, bus.req_ready_o);
        else passed++;
        @(posedge clk); @(negedge clk);
        bus.req_valid_i = 1'b0;
        total++; if (bus.req_ready_o !== 1'b0) $display("FAIL bp_next_accept got rdy=%b want 0", bus.req_ready_o); else passed++;
        lat = 0;
        while (!bus.rsp_valid_o && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        total++;
        if ({lat, bus.rsp_err_o, bus.rsp_rdata_o} !== {32'sd3, 1'b0, 32'h1122_3344})
            $display("FAIL bp_next_rsp got lat=%0d e=%b d=%h want 3/0/11223344", lat, bus.rsp_err_o, bus.rsp_rdata_o);
        else passed++;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 2'b10, 1'b0, 32'h1000_0010, 32'h0BAD_C0DE, rd, er, lat);
        bus.req_we_i = 1'b1; bus.req_size_i = 2'b10; bus.req_unsigned_i = 1'b0;
        bus.req_addr_i = 32'h1000_0010; bus.req_wdata_i = 32'hCAFE_F00D;
        bus.req_valid_i = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(posedge clk); @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o} !== {1'b1, 1'b0, 1'b0, 32'd0})
            $display("FAIL midreset_outputs got rdy=%b v=%b e=%b d=%h want 1/0/0/0",
                     bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o);
        else passed++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        xact(1'b0, 2'b10, 1'b0, 32'h1000_0010, 32'd0, rd, er, lat);
        total++; if ({er, rd} !== {1'b0, 32'h0BAD_C0DE}) $display("FAIL midreset_no_write got err=%b rdata=%h want 0/0badc0de", er, rd); else passed++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_misaligned();
        test_range();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
